// File: rtl/tap_controller_if.sv
// Signal bundle between a JTAG TAP controller and the logic that drives TMS and consumes the state and strobes.
interface tap_controller_if;
    logic       tms;
    logic [3:0] state;
    logic       tl_reset;
    logic       select;
    logic       capture_ir;
    logic       shift_ir;
    logic       update_ir;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       tdo_en;

    modport master (
        output tms,
        input  state, tl_reset, select,
        input  capture_ir, shift_ir, update_ir,
        input  capture_dr, shift_dr, update_dr,
        input  tdo_en
    );

    modport slave (
        input  tms,
        output state, tl_reset, select,
        output capture_ir, shift_ir, update_ir,
        output capture_dr, shift_dr, update_dr,
        output tdo_en
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP state machine using the standard 4-bit state encoding.
// Strobes are registered from the next state so they line up exactly with the state register.
module tap_controller (
    input  logic             tck,
    input  logic             trst,
    tap_controller_if.slave  bus
);

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    tap_state_t state_q;
    tap_state_t state_d;
    logic       tl_reset_q;
    logic       select_q;
    logic       capture_ir_q;
    logic       shift_ir_q;
    logic       update_ir_q;
    logic       capture_dr_q;
    logic       shift_dr_q;
    logic       update_dr_q;
    logic       tdo_en_q;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q      <= TEST_LOGIC_RESET;
            tl_reset_q   <= 1'b0;
            select_q     <= 1'b1;
            capture_ir_q <= 1'b0;
            shift_ir_q   <= 1'b0;
            update_ir_q  <= 1'b0;
            capture_dr_q <= 1'b0;
            shift_dr_q   <= 1'b0;
            update_dr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tl_reset_q   <= (state_d != TEST_LOGIC_RESET);
            select_q     <= state_d[3];
            capture_ir_q <= (state_d == CAPTURE_IR);
            shift_ir_q   <= (state_d == SHIFT_IR);
            update_ir_q  <= (state_d == UPDATE_IR);
            capture_dr_q <= (state_d == CAPTURE_DR);
            shift_dr_q   <= (state_d == SHIFT_DR);
            update_dr_q  <= (state_d == UPDATE_DR);
        end
    end

    always_comb begin
        state_d = TEST_LOGIC_RESET;
        case (state_q)
            TEST_LOGIC_RESET: state_d = bus.tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = bus.tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = bus.tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            SELECT_IR_SCAN:   state_d = bus.tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_DR:       state_d = bus.tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = bus.tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = bus.tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = bus.tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = bus.tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = bus.tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            CAPTURE_IR:       state_d = bus.tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = bus.tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = bus.tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = bus.tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = bus.tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = bus.tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    // TDO enable moves on the falling edge so the shifted bit is driven half a cycle after the state changes.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= (state_q == SHIFT_IR) || (state_q == SHIFT_DR);
        end
    end

    assign bus.state      = state_q;
    assign bus.tl_reset   = tl_reset_q;
    assign bus.select     = select_q;
    assign bus.capture_ir = capture_ir_q;
    assign bus.shift_ir   = shift_ir_q;
    assign bus.update_ir  = update_ir_q;
    assign bus.capture_dr = capture_dr_q;
    assign bus.shift_dr   = shift_dr_q;
    assign bus.update_dr  = update_dr_q;
    assign bus.tdo_en     = tdo_en_q;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: table-driven sequences, exhaustive (state, tms) sweep,
// async-reset aborts and random TMS walks against a transition-table model.
module tb_tap_controller;

    localparam int E2D = 0,  E1D = 1,  SHD = 2,  PSD = 3;
    localparam int SIR = 4,  UPD = 5,  CPD = 6,  SDR = 7;
    localparam int SHI = 10, RTI = 12, UPI = 13, CPI = 14, TLR = 15;

    logic tck  = 1'b0;
    logic trst = 1'b1;

    tap_controller_if bus ();

    tap_controller dut (
        .tck  (tck),
        .trst (trst),
        .bus  (bus.slave)
    );

    always #5 tck = ~tck;

    int total = 0;
    int bad   = 0;

    int nextTab [16][2];
    int parent [16];
    bit parentTms [16];
    int modelState = TLR;

    typedef struct {
        bit         tms;
        logic [3:0] st;
        bit         capIr;
        bit         updIr;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [5:0] expStrobes(input int s);
        return {s == CPI, s == SHI, s == UPI, s == CPD, s == SHD, s == UPD};
    endfunction

    function automatic bit isShift(input int s);
        return (s == SHD) || (s == SHI);
    endfunction

    function automatic logic [5:0] actStrobes();
        return {bus.capture_ir, bus.shift_ir, bus.update_ir,
                bus.capture_dr, bus.shift_dr, bus.update_dr};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The DR and IR columns share one shape, offset by 8 in the encoding.
    task automatic buildModel();
        int q [$];
        bit seen [16];
        int s;
        int n;
        nextTab[TLR] = '{RTI, TLR};
        nextTab[RTI] = '{RTI, SDR};
        nextTab[SDR] = '{CPD, SIR};
        nextTab[SIR] = '{CPI, TLR};
        for (int col = 0; col <= 8; col += 8) begin
            nextTab[CPD + col] = '{SHD + col, E1D + col};
            nextTab[SHD + col] = '{SHD + col, E1D + col};
            nextTab[E1D + col] = '{PSD + col, UPD + col};
            nextTab[PSD + col] = '{PSD + col, E2D + col};
            nextTab[E2D + col] = '{SHD + col, UPD + col};
            nextTab[UPD + col] = '{RTI, SDR};
        end
        nextTab[CPI] = '{SHI, E1D + 8};
        foreach (seen[i]) seen[i] = 1'b0;
        seen[TLR] = 1'b1;
        q.push_back(TLR);
        while (q.size() > 0) begin
            s = q.pop_front();
            for (int t = 0; t < 2; t++) begin
                n = nextTab[s][t];
                if (!seen[n]) begin
                    seen[n]      = 1'b1;
                    parent[n]    = s;
                    parentTms[n] = t[0];
                    q.push_back(n);
                end
            end
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_state"}, 32'(bus.state), 32'hF);
        checkOutput({tag, "_tl_reset"}, 32'(bus.tl_reset), 32'd0);
        checkOutput({tag, "_select"}, 32'(bus.select), 32'd1);
        checkOutput({tag, "_strobes"}, 32'(actStrobes()), 32'd0);
        checkOutput({tag, "_tdo_en"}, 32'(bus.tdo_en), 32'd0);
    endtask

    // Called at negedge+1; leaves the bench at negedge+1 one cycle later.
    task automatic applyStimulus(input bit t);
        int prev;
        prev     = modelState;
        bus.tms  = t;
        @(posedge tck);
        #1;
        modelState = nextTab[modelState][t];
        checkOutput("state", 32'(bus.state), 32'(modelState));
        checkOutput("strobes", 32'(actStrobes()), 32'(expStrobes(modelState)));
        checkOutput("onehot0", 32'($onehot0(actStrobes())), 32'd1);
        checkOutput("tl_reset", 32'(bus.tl_reset), 32'(modelState != TLR));
        checkOutput("select", 32'(bus.select), 32'(modelState >= 8));
        checkOutput("tdo_en_lag", 32'(bus.tdo_en), 32'(isShift(prev)));
        @(negedge tck);
        #1;
        checkOutput("tdo_en", 32'(bus.tdo_en), 32'(isShift(modelState)));
    endtask

    // TCK and TMS keep toggling while TRST is held; nothing may move.
    task automatic doReset();
        trst    = 1'b0;
        bus.tms = 1'b0;
        #1;
        checkReset("rst");
        repeat (2) begin
            @(posedge tck);
            bus.tms = ~bus.tms;
        end
        #1;
        checkOutput("rst_hold_state", 32'(bus.state), 32'hF);
        @(negedge tck);
        #1;
        trst       = 1'b1;
        modelState = TLR;
    endtask

    task automatic asyncAbort(input string tag);
        trst = 1'b0;
        #1;
        checkReset(tag);
        @(negedge tck);
        #1;
        trst       = 1'b1;
        modelState = TLR;
    endtask

    task automatic navigate(input int target);
        bit path [$];
        int s;
        s = target;
        while (s != TLR) begin
            path.push_front(parentTms[s]);
            s = parent[s];
        end
        foreach (path[i]) applyStimulus(path[i]);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.tms = 1'b0;
        buildModel();
        vecs[0] = '{1'b0, 4'hC, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'h7, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'h4, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 4'hE, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 4'hA, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 4'h9, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 4'hB, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 4'h8, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 4'hD, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 4'hC, 1'b0, 1'b0};

        $display("[TB] reset and fixed IR scan sequence");
        doReset();
        applyStimulus(1'b1);
        checkOutput("tlr_hold", 32'(bus.state), 32'hF);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].tms);
            checkOutput("vec_state", 32'(bus.state), 32'(vecs[i].st));
            checkOutput("vec_capture_ir", 32'(bus.capture_ir), 32'(vecs[i].capIr));
            checkOutput("vec_update_ir", 32'(bus.update_ir), 32'(vecs[i].updIr));
            checkOutput("vec_tl_reset", 32'(bus.tl_reset), 32'd1);
        end

        $display("[TB] first edge after reset release");
        doReset();
        applyStimulus(1'b0);
        checkOutput("first_edge", 32'(bus.state), 32'hC);

        $display("[TB] abort mid-shift and during update");
        doReset();
        navigate(SHD);
        applyStimulus(1'b0);
        checkOutput("pre_abort_shift_dr", 32'(bus.shift_dr), 32'd1);
        checkOutput("pre_abort_tdo_en", 32'(bus.tdo_en), 32'd1);
        asyncAbort("abort_shift");
        navigate(UPD);
        checkOutput("pre_abort_update_dr", 32'(bus.update_dr), 32'd1);
        asyncAbort("abort_update");

        $display("[TB] tdo_en half-cycle timing");
        doReset();
        navigate(CPD);
        bus.tms = 1'b0;
        @(posedge tck);
        #1;
        checkOutput("tdo_entry_posedge", 32'(bus.tdo_en), 32'd0);
        @(negedge tck);
        #1;
        checkOutput("tdo_rise", 32'(bus.tdo_en), 32'd1);
        modelState = SHD;
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        bus.tms = 1'b1;
        @(posedge tck);
        #1;
        checkOutput("exit1_state", 32'(bus.state), 32'h1);
        checkOutput("tdo_exit_posedge", 32'(bus.tdo_en), 32'd1);
        @(negedge tck);
        #1;
        checkOutput("tdo_fall", 32'(bus.tdo_en), 32'd0);
        modelState = E1D;

        $display("[TB] five TMS=1 from every state");
        for (int s = 0; s < 16; s++) begin
            doReset();
            navigate(s);
            repeat (5) applyStimulus(1'b1);
            checkOutput("tms5_state", 32'(bus.state), 32'hF);
            checkOutput("tms5_tl_reset", 32'(bus.tl_reset), 32'd0);
        end

        $display("[TB] exhaustive state x tms sweep");
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 2; t++) begin
                doReset();
                navigate(s);
                applyStimulus(t[0]);
            end
        end

        $display("[TB] random walk");
        doReset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                asyncAbort("rand_abort");
            end else begin
                applyStimulus($urandom_range(0, 9) < 3);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tap_controller.md
TAP_CONTROLLER -- requirements
Module: tap_controller

Interface
REQ-001 Parameters: none; the state encoding is fixed by REQ-010.
REQ-002 tck  input  1  test clock; the only clock; all state updates on posedge, except tdo_en.
REQ-003 trst  input  1  asynchronous, active-low reset; forces TEST-LOGIC-RESET.
REQ-004 tms  input  1  test mode select, sampled on posedge tck.
REQ-005 state  output  4  current TAP state, encoded per REQ-010.
REQ-006 tl_reset  output  1  active-low test-logic reset; low while in TEST-LOGIC-RESET; drives the instruction register's tl_reset.
REQ-007 select  output  1  1 = IR path selected for TDO mux (state[3]==1), 0 = DR path.
REQ-008 capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr  output  1 each  single-state strobes.
REQ-009 tdo_en  output  1  TDO drive enable; high only during shift states, changes on negedge tck.

Function
REQ-010 State encoding (IEEE 1149.1): EXIT2-DR 0x0, EXIT1-DR 0x1, SHIFT-DR 0x2, PAUSE-DR 0x3, SELECT-IR-SCAN 0x4, UPDATE-DR 0x5, CAPTURE-DR 0x6, SELECT-DR-SCAN 0x7, EXIT2-IR 0x8, EXIT1-IR 0x9, SHIFT-IR 0xA, PAUSE-IR 0xB, RUN-TEST/IDLE 0xC, UPDATE-IR 0xD, CAPTURE-IR 0xE, TEST-LOGIC-RESET 0xF.
REQ-011 Transitions (tms=0 / tms=1): TLR: RTI / TLR; RTI: RTI / SEL-DR; SEL-DR: CAP-DR / SEL-IR; SEL-IR: CAP-IR / TLR.
REQ-012 DR column (tms=0 / tms=1): CAP-DR: SHIFT-DR / EXIT1-DR; SHIFT-DR: SHIFT-DR / EXIT1-DR; EXIT1-DR: PAUSE-DR / UPDATE-DR; PAUSE-DR: PAUSE-DR / EXIT2-DR; EXIT2-DR: SHIFT-DR / UPDATE-DR; UPDATE-DR: RTI / SEL-DR.
REQ-013 IR column: identical to REQ-012 with IR states substituted for DR states.
REQ-014 All 16 encodings are reachable; no illegal states exist; a default branch returns to TLR.
REQ-015 The state register and all strobe outputs are registered on posedge tck, computed from next state; they are glitch-free and coincide exactly with state.
REQ-016 Each strobe is high for exactly the cycles state equals its state: capture_ir=CAP-IR, shift_ir=SHIFT-IR, update_ir=UPDATE-IR, capture_dr=CAP-DR, shift_dr=SHIFT-DR, update_dr=UPDATE-DR.
REQ-017 At most one strobe is high in any cycle.
REQ-018 update_ir and update_dr rise on the posedge entering UPDATE-xR and fall on the next posedge; each is a clean edge usable as a latch clock.
REQ-019 tl_reset = 0 exactly while state = TLR, registered with state; it returns to 1 on the posedge that leaves TLR.
REQ-020 select = state[3], registered.
REQ-021 tdo_en is captured on negedge tck: high iff state is SHIFT-IR or SHIFT-DR; it lags state by half a cycle.
REQ-022 tms=1 for 5 consecutive posedges reaches TLR from any state.
REQ-023 trst low during any operation (including mid-shift or during UPDATE) aborts it immediately; in-progress strobes fall with no further edge.

Reset
REQ-024 On trst low, asynchronously: state=0xF, tl_reset=0, select=1, all six strobes=0, tdo_en=0.
REQ-025 While trst is low, tck and tms are ignored; the first posedge after trst release applies REQ-011 from TLR.

Verification
REQ-026 trst pulsed low while in SHIFT-DR with shift_dr=1 and tdo_en=1 -> state=0xF, shift_dr=0, tdo_en=0, tl_reset=0, all without a tck edge.
REQ-027 From TLR, tms=0,1,1,0,0 -> states 0xC,0x7,0x4,0xE,0xA; capture_ir high for exactly one cycle; tl_reset=1 from the first edge.
REQ-028 From each of the 16 states, tms=1 for 5 posedges -> state=0xF and tl_reset=0.
REQ-029 In SHIFT-IR, tms=1,0,1,1,0 -> 0x9,0xB,0x8,0xD,0xC; update_ir high for one cycle only, in state 0xD.
REQ-030 Enter SHIFT-DR, hold 3 cycles, then tms=1 -> tdo_en rises at the negedge after entry and falls at the negedge after EXIT1-DR (0x1).
REQ-031 Exhaustive: all 32 (state, tms) pairs checked against REQ-011..013; strobes checked one-hot-or-zero every cycle.
